// File: rtl/char_console_if.sv
// Byte-stream input and VRAM write-port bundle for char_console_writer.
// The master modport is the writer side; the slave modport is the byte source / VRAM side.
interface char_console_if;
  logic        i_ch_valid;
  logic [7:0]  i_ch_data;
  logic [11:0] i_color;
  logic        o_ch_ready;
  logic [15:0] o_wraddr;
  logic [3:0]  o_byteen;
  logic        o_wren;
  logic [31:0] o_wrdata;
  logic [6:0]  o_cur_col;
  logic [5:0]  o_cur_row;
  logic        o_busy;

  modport master (
    input  i_ch_valid, i_ch_data, i_color,
    output o_ch_ready, o_wraddr, o_byteen, o_wren, o_wrdata,
    output o_cur_col, o_cur_row, o_busy
  );

  modport slave (
    output i_ch_valid, i_ch_data, i_color,
    input  o_ch_ready, o_wraddr, o_byteen, o_wren, o_wrdata,
    input  o_cur_col, o_cur_row, o_busy
  );
endinterface

// File: rtl/char_console_writer.sv
// Terminal-style writer: ASCII stream in, cursor-tracked VRAM word writes out.
// Optional macro CLRLINE_EN clears each newly entered row when the cursor advances a row.
module char_console_writer #(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 50,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  char_console_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_CLEAR  = 2'd2
  } state_t;

  localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW     = 6'(ROWS - 1);
  localparam logic [11:0] SCREEN_CELLS = 12'(COLS * ROWS);
  localparam logic [11:0] ROW_CELLS    = 12'(COLS);
`ifdef CLRLINE_EN
  localparam logic        LINE_CLEAR   = 1'b1;
`else
  localparam logic        LINE_CLEAR   = 1'b0;
`endif

  // row*80 as (row<<6)+(row<<4), kept to 12 bits
  function automatic logic [11:0] f_cell_idx(input logic [5:0] row, input logic [6:0] col);
    f_cell_idx = {row, 6'd0} + {2'd0, row, 4'd0} + {5'd0, col};
  endfunction

  function automatic logic [15:0] f_addr(input logic [11:0] idx);
    f_addr = {2'b00, idx, 2'b00};
  endfunction

  function automatic logic [31:0] f_word(input logic [11:0] color, input logic [6:0] code);
    f_word = {12'h000, color, 1'b0, code};
  endfunction

  function automatic logic f_printable(input logic [7:0] b);
    f_printable = (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  state_t      r_state;
  logic [7:0]  r_ch;
  logic [11:0] r_color;
  logic [6:0]  r_col;
  logic [5:0]  r_row;
  logic [11:0] r_idx;
  logic [11:0] r_clr_end;
  logic        r_ready;
  logic        r_busy;
  logic        r_wren;
  logic [3:0]  r_byteen;
  logic [15:0] r_wraddr;
  logic [31:0] r_wrdata;

  logic        w_accept;
  logic [5:0]  w_row_inc;
  logic [6:0]  w_next_col;
  logic [5:0]  w_next_row;
  logic        w_row_adv;
  logic        w_ff;
  logic        w_clr_go;
  logic [11:0] w_clr_start;
  logic [11:0] w_clr_end;

  assign w_accept = bus.i_ch_valid & r_ready;

  // Cursor update for the byte held in r_ch
  always_comb begin
    w_row_inc  = (r_row == LAST_ROW) ? 6'd0 : (r_row + 6'd1);
    w_next_col = r_col;
    w_next_row = r_row;
    w_row_adv  = 1'b0;
    w_ff       = 1'b0;
    if (f_printable(r_ch)) begin
      if (r_col == LAST_COL) begin
        w_next_col = 7'd0;
        w_next_row = w_row_inc;
        w_row_adv  = 1'b1;
      end else begin
        w_next_col = r_col + 7'd1;
      end
    end else begin
      case (r_ch)
        8'h0D: w_next_col = 7'd0;
        8'h0A: begin
          w_next_row = w_row_inc;
          w_row_adv  = 1'b1;
        end
        8'h08: begin
          if (r_col != 7'd0) begin
            w_next_col = r_col - 7'd1;
          end else begin
            w_next_col = r_col;
          end
        end
        8'h0C: begin
          w_next_col = 7'd0;
          w_next_row = 6'd0;
          w_ff       = 1'b1;
        end
        default: w_next_col = r_col;
      endcase
    end
  end

  // Clear range selection: whole screen for FF, the newly entered row for a line clear
  always_comb begin
    w_clr_go = w_ff | (LINE_CLEAR & w_row_adv);
    if (w_ff) begin
      w_clr_start = 12'd0;
      w_clr_end   = SCREEN_CELLS;
    end else begin
      w_clr_start = f_cell_idx(w_next_row, 7'd0);
      w_clr_end   = f_cell_idx(w_next_row, 7'd0) + ROW_CELLS;
    end
  end

  // Control FSM with registered bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= 8'h00;
      r_color   <= 12'h000;
      r_col     <= 7'd0;
      r_row     <= 6'd0;
      r_idx     <= 12'd0;
      r_clr_end <= 12'd0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_wren    <= 1'b0;
      r_byteen  <= 4'b0000;
      r_wraddr  <= 16'h0000;
      r_wrdata  <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_ch    <= bus.i_ch_data;
            r_color <= bus.i_color;
            r_ready <= 1'b0;
            r_state <= S_DECODE;
            // Printable bytes are written during the decode cycle itself
            if (f_printable(bus.i_ch_data)) begin
              r_wren   <= 1'b1;
              r_byteen <= 4'b0111;
              r_wraddr <= f_addr(f_cell_idx(r_row, r_col));
              r_wrdata <= f_word(bus.i_color, bus.i_ch_data[6:0]);
            end else begin
              r_wren   <= 1'b0;
              r_byteen <= 4'b0000;
            end
          end else begin
            r_ready  <= 1'b1;
            r_wren   <= 1'b0;
            r_byteen <= 4'b0000;
          end
        end
        S_DECODE: begin
          r_col <= w_next_col;
          r_row <= w_next_row;
          if (w_clr_go) begin
            r_state   <= S_CLEAR;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_wren    <= 1'b1;
            r_byteen  <= 4'b0111;
            r_wraddr  <= f_addr(w_clr_start);
            r_wrdata  <= f_word(r_color, CLR_CHAR[6:0]);
            r_idx     <= w_clr_start + 12'd1;
            r_clr_end <= w_clr_end;
          end else begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_wren   <= 1'b0;
            r_byteen <= 4'b0000;
          end
        end
        S_CLEAR: begin
          // r_idx is the next cell to write; r_clr_end is one past the last
          if (r_idx == r_clr_end) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_wren   <= 1'b0;
            r_byteen <= 4'b0000;
          end else begin
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_wren   <= 1'b1;
            r_byteen <= 4'b0111;
            r_wraddr <= f_addr(r_idx);
            r_idx    <= r_idx + 12'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_ready  <= 1'b0;
          r_wren   <= 1'b0;
          r_byteen <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.o_ch_ready = r_ready;
  assign bus.o_wraddr   = r_wraddr;
  assign bus.o_byteen   = r_byteen;
  assign bus.o_wren     = r_wren;
  assign bus.o_wrdata   = r_wrdata;
  assign bus.o_cur_col  = r_col;
  assign bus.o_cur_row  = r_row;
  assign bus.o_busy     = r_busy;

endmodule
